fetch_pc_ctrl: RTL and testbench

FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

---
 rtl/fetch_pc_ctrl.sv | 71 +++++++
 tb/tb_fetch_pc_ctrl.sv | 90 +++++++++
 2 files changed

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: fetch PC sequencing with EX-stage redirects, pending-target hold and flush generation
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_br_taken,
    input  logic [31:0]      ex_irreg_pc,
    input  logic             stall,
    input  logic             imem_ready,
    output logic [31:0]      fetch_pc,
    output logic             fetch_req,
    output logic             flush,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redirect_cnt
);
    typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;
    state_t      state, state_nx;
    logic [31:0] pc_nx, tgt_q, tgt_nx, tgt;
    logic        redir;
    assign tgt       = {ex_irreg_pc[31:2], 2'b00};
    assign redir     = ex_valid & ex_is_branch & ex_br_taken & (state != PEND) & ~flush;
    assign fetch_req = state != BOOT;
    // next PC / state: a redirect that memory cannot accept yet is parked in tgt_q until imem_ready
    always_comb begin
        state_nx = state;
        pc_nx    = fetch_pc;
        tgt_nx   = tgt_q;
        case (state)
            BOOT: begin
                state_nx = RUN;
                pc_nx    = redir ? tgt : fetch_pc;
            end
            RUN: begin
                if (redir && imem_ready) pc_nx = tgt;
                else if (redir) begin
                    tgt_nx   = tgt;
                    state_nx = PEND;
                end else if (!stall && imem_ready) pc_nx = fetch_pc + 32'd4;
            end
            PEND: begin
                if (imem_ready) begin
                    pc_nx    = tgt_q;
                    state_nx = RUN;
                end
            end
            default: state_nx = BOOT;
        endcase
    end
    // state, PC, flush pulse, redirect counter and sticky misalignment flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT;
            fetch_pc     <= RESET_PC;
            tgt_q        <= 32'd0;
            flush        <= 1'b0;
            misalign_err <= 1'b0;
            redirect_cnt <= '0;
        end else begin
            state        <= state_nx;
            fetch_pc     <= pc_nx;
            tgt_q        <= tgt_nx;
            flush        <= redir;
            misalign_err <= misalign_err | (redir & |ex_irreg_pc[1:0]);
            redirect_cnt <= redirect_cnt + CNT_W'(redir);
        end
    end
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: scoreboard bench for fetch_pc_ctrl with per-cycle expected outputs
module tb_fetch_pc_ctrl;
    logic        clk = 1'b0;
    logic        rst, ex_valid, ex_is_branch, ex_br_taken, stall, imem_ready;
    logic [31:0] ex_irreg_pc, fetch_pc, redirect_cnt;
    logic        fetch_req, flush, misalign_err;
    int          n_tests = 0, n_fail = 0;

    typedef struct {
        logic [31:0] pc;
        logic        req, fl, mis;
        logic [31:0] cnt;
    } exp_t;
    exp_t sb[$];

    fetch_pc_ctrl #(.RESET_PC(32'h0), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_br_taken(ex_br_taken), .ex_irreg_pc(ex_irreg_pc), .stall(stall),
        .imem_ready(imem_ready), .fetch_pc(fetch_pc), .fetch_req(fetch_req),
        .flush(flush), .misalign_err(misalign_err), .redirect_cnt(redirect_cnt)
    );

    // free-running clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // drive one cycle of inputs, queue the post-edge expectation, clock, then pop and compare
    task automatic cyc(input string tag, input logic [2:0] ev, input logic [31:0] t, input logic st,
                       input logic rdy, input logic [31:0] epc, input logic ereq, input logic efl,
                       input logic emis, input logic [31:0] ecnt);
        exp_t e;
        {ex_valid, ex_is_branch, ex_br_taken} = ev;
        ex_irreg_pc = t;
        stall       = st;
        imem_ready  = rdy;
        sb.push_back('{pc: epc, req: ereq, fl: efl, mis: emis, cnt: ecnt});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".pc"},    fetch_pc,          e.pc);
        check({tag, ".req"},   {31'd0, fetch_req}, {31'd0, e.req});
        check({tag, ".flush"}, {31'd0, flush},     {31'd0, e.fl});
        check({tag, ".mis"},   {31'd0, misalign_err}, {31'd0, e.mis});
        check({tag, ".cnt"},   redirect_cnt,      e.cnt);
    endtask

    initial begin
        rst = 1'b1;
        cyc("reset",      3'b000, 0, 0, 1, 32'h0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc("boot",       3'b000, 0, 0, 1, 32'h0, 1, 0, 0, 0);
        cyc("seq4",       3'b000, 0, 0, 1, 32'h4, 1, 0, 0, 0);
        cyc("seq8",       3'b000, 0, 0, 1, 32'h8, 1, 0, 0, 0);
        cyc("seqc",       3'b000, 0, 0, 1, 32'hC, 1, 0, 0, 0);
        cyc("seq10",      3'b000, 0, 0, 1, 32'h10, 1, 0, 0, 0);
        cyc("redir_stl",  3'b111, 32'h100, 1, 1, 32'h100, 1, 1, 0, 1);
        cyc("in_flush",   3'b111, 32'h700, 0, 1, 32'h104, 1, 0, 0, 1);
        cyc("stall",      3'b000, 0, 1, 1, 32'h104, 1, 0, 0, 1);
        cyc("not_ready",  3'b000, 0, 0, 0, 32'h104, 1, 0, 0, 1);
        cyc("not_taken",  3'b110, 32'h500, 0, 1, 32'h108, 1, 0, 0, 1);
        cyc("not_valid",  3'b011, 32'h500, 0, 1, 32'h10C, 1, 0, 0, 1);
        cyc("pend_in",    3'b111, 32'h200, 0, 0, 32'h10C, 1, 1, 0, 2);
        cyc("pend_ign",   3'b111, 32'h600, 0, 0, 32'h10C, 1, 0, 0, 2);
        cyc("pend_hold",  3'b000, 0, 1, 0, 32'h10C, 1, 0, 0, 2);
        cyc("pend_out",   3'b000, 0, 1, 1, 32'h200, 1, 0, 0, 2);
        cyc("post_pend",  3'b000, 0, 0, 1, 32'h204, 1, 0, 0, 2);
        cyc("misalign",   3'b111, 32'h103, 0, 1, 32'h100, 1, 1, 1, 3);
        cyc("mis_stick",  3'b000, 0, 0, 1, 32'h104, 1, 0, 1, 3);
        cyc("redir_ok",   3'b111, 32'h400, 0, 1, 32'h400, 1, 1, 1, 4);
        cyc("mis_stick2", 3'b000, 0, 0, 1, 32'h404, 1, 0, 1, 4);
        cyc("to_top",     3'b111, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, 1, 1, 1, 5);
        cyc("wrap",       3'b000, 0, 0, 1, 32'h0, 1, 0, 1, 5);
        cyc("after_wrap", 3'b000, 0, 0, 1, 32'h4, 1, 0, 1, 5);
        cyc("pend2",      3'b111, 32'h800, 0, 0, 32'h4, 1, 1, 1, 6);
        rst = 1'b1;
        cyc("rst_pend",   3'b111, 32'h900, 0, 1, 32'h0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc("reboot",     3'b000, 0, 0, 1, 32'h0, 1, 0, 0, 0);
        cyc("rerun",      3'b000, 0, 0, 1, 32'h4, 1, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
